// File: rtl/sieve_pkg.sv
// Shared state encodings and constants for the prime-sieve sequencer.
package sieve_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_CLEAR    = 3'd1;
    localparam state_t S_SIEVE    = 3'd2;
    localparam state_t S_SCAN_RD  = 3'd3;
    localparam state_t S_SCAN_CHK = 3'd4;
    localparam state_t S_EMIT     = 3'd5;
    localparam state_t S_DONE     = 3'd6;

    localparam int FIRST_CANDIDATE = 2;
    localparam int UNMARKED        = 0;

endpackage

// File: rtl/sieve_ram_mux.sv
// RAM-port owner mux: the sieve engine drives the RAM only while in SIEVE.
module sieve_ram_mux
    import sieve_pkg::*;
#(
    parameter int ADDR = 8,
    parameter int DATA = 8
) (
    input  state_t            state,
    input  logic [ADDR-1:0]   sieve_addr,
    input  logic              sieve_wr,
    input  logic [DATA-1:0]   sieve_dout,
    input  logic [ADDR-1:0]   ctrl_addr,
    input  logic              ctrl_wr,
    input  logic [DATA-1:0]   ctrl_din,
    output logic [ADDR-1:0]   ram_addr,
    output logic              ram_wr,
    output logic [DATA-1:0]   ram_din
);

    logic own;

    assign own      = (state == S_SIEVE);
    assign ram_addr = own ? sieve_addr : ctrl_addr;
    assign ram_wr   = own ? sieve_wr   : ctrl_wr;
    assign ram_din  = own ? sieve_dout : ctrl_din;

endmodule

// File: rtl/sieve_ctrl.sv
// Prime-sieve sequencer: clears RAM, runs the sieve engine, then streams
// every unmarked address >= 2 as a prime over a valid/ready port.
module sieve_ctrl
    import sieve_pkg::*;
#(
    parameter int ADDR = 8,
    parameter int DATA = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              sieve_rst,
    input  logic [ADDR-1:0]   sieve_addr,
    input  logic              sieve_wr,
    input  logic [DATA-1:0]   sieve_dout,
    output logic [DATA-1:0]   sieve_din,
    input  logic              sieve_done,
    output logic [ADDR-1:0]   ram_addr,
    output logic              ram_wr,
    output logic [DATA-1:0]   ram_din,
    input  logic [DATA-1:0]   ram_dout,
    output logic [ADDR-1:0]   prime,
    output logic              prime_valid,
    input  logic              prime_ready,
    output logic [ADDR-1:0]   prime_count
);

    localparam logic [ADDR-1:0] LAST  = {ADDR{1'b1}};
    localparam logic [ADDR-1:0] FIRST = ADDR'(FIRST_CANDIDATE);

    state_t          state;
    logic [ADDR-1:0] ptr;
    logic            ptr_last;
    logic            unmarked;

    assign ptr_last    = (ptr == LAST);
    assign unmarked    = (ram_dout == DATA'(UNMARKED));
    assign sieve_rst   = (state != S_SIEVE);
    assign sieve_din   = ram_dout;
    assign prime_valid = (state == S_EMIT);

    // Controller always addresses the RAM through ptr; only CLEAR writes.
    sieve_ram_mux #(
        .ADDR (ADDR),
        .DATA (DATA)
    ) u_mux (
        .state      (state),
        .sieve_addr (sieve_addr),
        .sieve_wr   (sieve_wr),
        .sieve_dout (sieve_dout),
        .ctrl_addr  (ptr),
        .ctrl_wr    (state == S_CLEAR),
        .ctrl_din   ('0),
        .ram_addr   (ram_addr),
        .ram_wr     (ram_wr),
        .ram_din    (ram_din)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            prime       <= '0;
            prime_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        ptr         <= '0;
                        prime_count <= '0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (ptr_last) begin
                        state <= S_SIEVE;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                S_SIEVE: begin
                    if (sieve_done) begin
                        ptr   <= FIRST;
                        state <= S_SCAN_RD;
                    end
                end
                S_SCAN_RD: begin
                    state <= S_SCAN_CHK;
                end
                S_SCAN_CHK: begin
                    if (unmarked) begin
                        prime <= ptr;
                        state <= S_EMIT;
                    end else if (ptr_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        ptr   <= ptr + 1'b1;
                        state <= S_SCAN_RD;
                    end
                end
                S_EMIT: begin
                    if (prime_ready) begin
                        prime_count <= prime_count + 1'b1;
                        if (ptr_last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= S_SCAN_RD;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sieve_ctrl.sv
// Directed bench for sieve_ctrl with a behavioural blockram and sieve engine.
module tb_sieve_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ready = 1'b1;
    logic       null_mode = 1'b0;
    logic       busy, done, sieve_rst, sieve_wr, sieve_done;
    logic [7:0] sieve_addr, sieve_dout, sieve_din;
    logic [7:0] ram_addr, ram_din, ram_dout;
    logic       ram_wr, prime_valid;
    logic [7:0] prime, prime_count;

    int ncmp = 0;
    int nerr = 0;
    int got[$];

    always #5 clk = ~clk;

    sieve_ctrl #(.ADDR(8), .DATA(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .sieve_rst   (sieve_rst),
        .sieve_addr  (sieve_addr),
        .sieve_wr    (sieve_wr),
        .sieve_dout  (sieve_dout),
        .sieve_din   (sieve_din),
        .sieve_done  (sieve_done),
        .ram_addr    (ram_addr),
        .ram_wr      (ram_wr),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout),
        .prime       (prime),
        .prime_valid (prime_valid),
        .prime_ready (ready),
        .prime_count (prime_count)
    );

    // Single-port RAM, one-cycle read latency.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Behavioural sieve engine: marks multiples of each unmarked i <= 15.
    localparam logic [1:0] E_RD = 2'd0, E_CHK = 2'd1, E_MARK = 2'd2, E_DN = 2'd3;
    logic [1:0] es;
    logic [9:0] si, sj;

    always @(posedge clk) begin
        if (sieve_rst) begin
            es <= E_RD;
            si <= 10'd2;
            sj <= 10'd0;
        end else begin
            case (es)
                E_RD: es <= E_CHK;
                E_CHK: begin
                    if (sieve_din == 8'd0) begin
                        sj <= si * si;
                        es <= E_MARK;
                    end else if (si == 10'd15) begin
                        es <= E_DN;
                    end else begin
                        si <= si + 10'd1;
                        es <= E_RD;
                    end
                end
                E_MARK: begin
                    if (sj + si > 10'd255) begin
                        if (si == 10'd15) es <= E_DN;
                        else begin
                            si <= si + 10'd1;
                            es <= E_RD;
                        end
                    end else begin
                        sj <= sj + si;
                    end
                end
                default: es <= E_DN;
            endcase
        end
    end

    assign sieve_addr = (es == E_MARK) ? sj[7:0] : si[7:0];
    assign sieve_wr   = (es == E_MARK) && !null_mode;
    assign sieve_dout = 8'd1;
    assign sieve_done = null_mode || (es == E_DN);

    always @(negedge clk) begin
        if (prime_valid && ready) got.push_back(int'(prime));
    end

    task automatic chk(input string tag, input int obs, input int exp);
        ncmp++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++)
            if (v % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_reset();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(prime_valid), 0);
        chk("rst_ram_wr", int'(ram_wr), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_din", int'(ram_din), 0);
        chk("rst_sieve_rst", int'(sieve_rst), 1);
        chk("rst_count", int'(prime_count), 0);
        chk("rst_prime", int'(prime), 0);
    endtask

    task automatic start_run(input bit poke);
        int n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_done", int'(done), 0);
        chk("start_count", int'(prime_count), 0);
        n = 0;
        while (ram_wr && n < 1000) begin
            n++;
            start = poke && (n == 10);
            @(negedge clk);
        end
        start = 1'b0;
        chk("clear_len", n, 256);
    endtask

    task automatic pulse_when_sieving();
        int n = 0;
        while (sieve_rst && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("sieve_entered", int'(sieve_rst), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!prime_valid && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("valid_seen", int'(prime_valid), 1);
    endtask

    task automatic wait_done(input int exp_count);
        int n = 0;
        while (!done && n < 20000) begin
            n++;
            @(negedge clk);
        end
        chk("end_done", int'(done), 1);
        chk("end_busy", int'(busy), 0);
        chk("end_count", int'(prime_count), exp_count);
    endtask

    task automatic check_stream(input int base, input bit all_vals);
        int exp[$];
        for (int v = 2; v < 256; v++)
            if (all_vals || is_prime(v)) exp.push_back(v);
        chk("stream_len", got.size() - base, exp.size());
        for (int k = 0; k < exp.size() && base + k < got.size(); k++)
            if (got[base + k] != exp[k])
                chk($sformatf("stream[%0d]", k), got[base + k], exp[k]);
        if (got.size() > base)
            chk("stream_last", got[got.size() - 1], all_vals ? 255 : 251);
    endtask

    initial begin
        int base;
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset();
        @(negedge clk);

        // Full run with ignored start pulses in CLEAR, SIEVE and EMIT
        base = got.size();
        start_run(1'b1);
        pulse_when_sieving();
        wait_valid();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(54);
        check_stream(base, 1'b0);

        // Back-to-back run started from DONE
        base = got.size();
        start_run(1'b0);
        wait_done(54);
        check_stream(base, 1'b0);

        // Null sieve: every candidate 2..255 is emitted
        null_mode = 1'b1;
        base = got.size();
        start_run(1'b0);
        wait_done(254);
        check_stream(base, 1'b1);
        null_mode = 1'b0;

        // Backpressure on the first prime
        ready = 1'b0;
        base = got.size();
        start_run(1'b0);
        wait_valid();
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", int'(prime_valid), 1);
            chk("bp_prime", int'(prime), 2);
            chk("bp_count", int'(prime_count), 0);
            @(negedge clk);
        end
        ready = 1'b1;
        wait_done(54);
        check_stream(base, 1'b0);

        // Reset while prime 13 is pending
        start_run(1'b0);
        n = 0;
        while (!(prime_valid && prime == 8'd13) && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("saw_13", int'(prime), 13);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset();
        @(negedge clk);
        base = got.size();
        start_run(1'b0);
        wait_done(54);
        check_stream(base, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
